example_4s_pipe: RTL and testbench

EXAMPLE_4S_PIPE -- requirements
Module: example_4s_pipe

---
 rtl/example_4s_pipe.sv | 142 ++++++++++++++
 tb/tb_example_4s_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/example_4s_pipe.sv
// Three-stage valid-tracked pipeline computing a per-bit boolean function of four operands,
// with global stall on output backpressure and a wrapping count of delivered results.
module example_4s_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     f,
    output logic             f_any,
    output logic [CNT_W-1:0] result_cnt
);

    logic adv;

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_t1_q, s1_t1_d;
    logic [W-1:0] s1_t2_q, s1_t2_d;
    logic [W-1:0] s1_t3_q, s1_t3_d;
    logic [W-1:0] s1_t4_q, s1_t4_d;
    logic [1:0]   s1_mode_q, s1_mode_d;

    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_t5_q, s2_t5_d;
    logic [W-1:0] s2_t6_q, s2_t6_d;
    logic [W-1:0] s2_t2_q, s2_t2_d;
    logic [1:0]   s2_mode_q, s2_mode_d;

    logic         s3_valid_q, s3_valid_d;
    logic [W-1:0] f_q, f_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W-1:0] fb;
    logic [W-1:0] res_sel;

    assign adv      = !s3_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        fb = (s2_t5_q & ~s2_t6_q) | (s2_t6_q & ~s2_t2_q);
        case (s2_mode_q)
            2'd0:    res_sel = fb;
            2'd1:    res_sel = s2_t5_q;
            2'd2:    res_sel = s2_t6_q;
            default: res_sel = ~fb;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_t1_d    = s1_t1_q;
        s1_t2_d    = s1_t2_q;
        s1_t3_d    = s1_t3_q;
        s1_t4_d    = s1_t4_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_t5_d    = s2_t5_q;
        s2_t6_d    = s2_t6_q;
        s2_t2_d    = s2_t2_q;
        s2_mode_d  = s2_mode_q;
        s3_valid_d = s3_valid_q;
        f_d        = f_q;
        cnt_d      = cnt_q;

        if (adv) begin
            s1_valid_d = in_valid;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
            // Data only loads with a valid beat so idle inputs never reach f.
            if (in_valid) begin
                s1_t1_d   = a & b;
                s1_t2_d   = c & d;
                s1_t3_d   = a ^ c;
                s1_t4_d   = b ^ d;
                s1_mode_d = mode;
            end
            if (s1_valid_q) begin
                s2_t5_d   = s1_t1_q | s1_t2_q;
                s2_t6_d   = s1_t3_q & ~s1_t4_q;
                s2_t2_d   = s1_t2_q;
                s2_mode_d = s1_mode_q;
            end
            if (s2_valid_q) begin
                f_d = res_sel;
            end
        end

        if (s3_valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_t1_q    <= '0;
            s1_t2_q    <= '0;
            s1_t3_q    <= '0;
            s1_t4_q    <= '0;
            s1_mode_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_t5_q    <= '0;
            s2_t6_q    <= '0;
            s2_t2_q    <= '0;
            s2_mode_q  <= '0;
            s3_valid_q <= 1'b0;
            f_q        <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_t1_q    <= s1_t1_d;
            s1_t2_q    <= s1_t2_d;
            s1_t3_q    <= s1_t3_d;
            s1_t4_q    <= s1_t4_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_t5_q    <= s2_t5_d;
            s2_t6_q    <= s2_t6_d;
            s2_t2_q    <= s2_t2_d;
            s2_mode_q  <= s2_mode_d;
            s3_valid_q <= s3_valid_d;
            f_q        <= f_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid  = s3_valid_q;
    assign f          = f_q;
    assign f_any      = |f_q;
    assign result_cnt = cnt_q;

endmodule

// File: tb/tb_example_4s_pipe.sv
// Bench for example_4s_pipe: directed corner cases plus randomized traffic checked against a
// queue-based reference model of the per-bit function.
module tb_example_4s_pipe;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a, b, c, d;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     f;
    logic             f_any;
    logic [CNT_W-1:0] result_cnt;

    example_4s_pipe #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f          (f),
        .f_any      (f_any),
        .result_cnt (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_tests = 0;
    int unsigned      n_fail  = 0;
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] cnt_exp = '0;
    logic             stall_prev = 1'b0;
    logic [W-1:0]     f_prev = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [W-1:0] mc, input logic [W-1:0] md,
                                           input logic [1:0] mm);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            bit x1, x2, x3, x4, x5, x6, xf;
            x1 = ma[i] && mb[i];
            x2 = mc[i] && md[i];
            x3 = ma[i] != mc[i];
            x4 = mb[i] != md[i];
            x5 = x1 || x2;
            x6 = x3 && !x4;
            xf = (x5 && !x6) || (x6 && !x2);
            case (mm)
                2'd0:    r[i] = xf;
                2'd1:    r[i] = x5;
                2'd2:    r[i] = x6;
                default: r[i] = !xf;
            endcase
        end
        return r;
    endfunction

    // Scoreboard: handshakes are judged just before the edge that completes them.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            check_eq("result_cnt", 32'(result_cnt), 32'(cnt_exp));
            if (stall_prev) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_f", 32'(f), 32'(f_prev));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    check_eq("f", 32'(f), 32'(exp_q[0]));
                    check_eq("f_any", 32'(f_any), 32'(|exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        cnt_exp = cnt_exp + 4'd1;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, c, d, mode));
            stall_prev = out_valid && !out_ready;
            f_prev     = f;
        end
    end

    // Returns on the clock edge that completes the input handshake.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                        input logic [W-1:0] td, input logic [1:0] tm);
        bit done;
        done = 1'b0;
        #1;
        a = ta; b = tb_; c = tc; d = td; mode = tm;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            @(posedge clk);
            if (!done) #1;
        end
        if (!done) check_eq("send_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
    endtask

    // Called right after send(): result must appear exactly on the third edge.
    task automatic check_latency(input string tag, input logic [W-1:0] exp_f, input logic exp_any);
        #1 in_valid = 1'b0;
        check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_lat3"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_f"}, 32'(f), 32'(exp_f));
        check_eq({tag, "_any"}, 32'(f_any), 32'(exp_any));
    endtask

    task automatic do_reset();
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_cnt", 32'(result_cnt), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        cnt_exp    = '0;
        stall_prev = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic drain(input int cycles);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [CNT_W-1:0] cnt0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0; mode = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Basic function
        send(8'hFF, 8'h00, 8'h00, 8'h00, 2'd0);
        check_latency("basic_m0", 8'hFF, 1'b1);
        send(8'hFF, 8'h00, 8'h00, 8'h00, 2'd1);
        check_latency("basic_m1", 8'h00, 1'b0);
        send(8'hFF, 8'h00, 8'h00, 8'h00, 2'd2);
        check_latency("basic_m2", 8'hFF, 1'b1);
        // Per-bit pattern in the low nibble; upper bits all zero
        send(8'h0C, 8'h0A, 8'h06, 8'h03, 2'd0);
        check_latency("bits_m0", 8'h08, 1'b1);
        send(8'h0C, 8'h0A, 8'h06, 8'h03, 2'd3);
        check_latency("bits_m3", 8'hF7, 1'b1);
        drain(3);

        // Ten back-to-back beats must all leave within three cycles of the last one
        do_reset();
        for (int i = 0; i < 10; i++) send_rand();
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("b2b_cnt", 32'(result_cnt), 32'd10);
        check_eq("b2b_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure with a fourth beat waiting
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        #1;
        a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
        mode = 2'($urandom);
        in_valid = 1'b1;
        cnt0 = cnt_exp;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_f", 32'(f), 32'(exp_q[0]));
            check_eq("bp_cnt", 32'(result_cnt), 32'(cnt0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        drain(6);
        check_eq("bp_total", 32'(result_cnt), 32'(cnt0 + 4'd4));

        // Counter wrap at CNT_W=4
        do_reset();
        for (int i = 0; i < 17; i++) send_rand();
        drain(4);
        check_eq("wrap_cnt", 32'(result_cnt), 32'd1);

        // Reset with beats in flight, then a beat on the first edge after release
        send_rand();
        send_rand();
        do_reset();
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0);
        check_latency("post_rst", 8'hFF, 1'b1);
        drain(3);
        check_eq("post_rst_cnt", 32'(result_cnt), 32'd1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
            mode = 2'($urandom);
        end
        @(posedge clk);
        drain(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
